// File: rtl/vc_demux2_dd_q_pkg.sv
// Shared definitions for the domain-tagged demux and its per-port queues.
//   DOM_W     : width of a security-domain tag
//   Q_DEPTH   : entries per output queue (the queue logic assumes 2)
//   NUM_PORTS : number of demux output ports
//   dom_e     : domain encodings shared by the domain-labelled blocks
//   cnt_next  : queue occupancy update for a given enq/deq pair
package vc_demux2_dd_q_pkg;

    localparam int DOM_W     = 2;
    localparam int Q_DEPTH   = 2;
    localparam int NUM_PORTS = 2;

    typedef enum logic [DOM_W-1:0] {
        DOM_PUBLIC = 2'd0,
        DOM_USER   = 2'd1,
        DOM_SECURE = 2'd2,
        DOM_ROOT   = 2'd3
    } dom_e;

    // Occupancy after one edge; enq and deq together leave it unchanged.
    function automatic logic [1:0] cnt_next(input logic [1:0] cnt,
                                            input logic       enq,
                                            input logic       deq);
        logic [1:0] n;
        n = cnt;
        if (enq && !deq)
            n = cnt + 2'd1;
        else if (deq && !enq)
            n = cnt - 2'd1;
        return n;
    endfunction

endpackage

// File: rtl/vc_demux2_dd_q_queue2.sv
// vc_queue2_dd: 2-entry scrubbing queue carrying {msg, domain}.
//   clk, reset          : clock, async active-high reset
//   enq_msg/enq_domain  : entry to write at the tail
//   enq_val/enq_rdy     : enqueue handshake; enq_rdy depends on count only
//   deq_msg/deq_domain  : head entry, forced to 0 when empty
//   deq_val/deq_rdy     : dequeue handshake; deq_val = queue non-empty
// Entries are cleared on the edge they are vacated, so no register ever
// holds data that has already left the queue.
module vc_queue2_dd
    import vc_demux2_dd_q_pkg::*;
#(
    parameter int p_nbits = 1,
    parameter int p_depth = Q_DEPTH
)(
    input  logic               clk,
    input  logic               reset,
    input  logic [p_nbits-1:0] enq_msg,
    input  logic [DOM_W-1:0]   enq_domain,
    input  logic               enq_val,
    output logic               enq_rdy,
    output logic [p_nbits-1:0] deq_msg,
    output logic [DOM_W-1:0]   deq_domain,
    output logic               deq_val,
    input  logic               deq_rdy
);

    logic [p_nbits-1:0] msg_q [2];
    logic [DOM_W-1:0]   dom_q [2];
    logic               head;
    logic               tail;
    logic [1:0]         count;
    logic               do_enq;
    logic               do_deq;

    // Full blocks enqueue even if the head leaves this edge: no pass-through.
    assign enq_rdy = (count < 2'(p_depth));
    assign deq_val = (count != 2'd0);
    assign do_enq  = enq_val && enq_rdy;
    assign do_deq  = deq_val && deq_rdy;

    // Msg and domain always from the same entry; gated so empty reads 0.
    assign deq_msg    = deq_val ? msg_q[head] : '0;
    assign deq_domain = deq_val ? dom_q[head] : '0;

    // With depth 2, enq and deq in the same edge only happen at count 1,
    // where head != tail, so the two writes never hit the same entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                msg_q[i] <= '0;
                dom_q[i] <= '0;
            end
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (do_deq) begin
                msg_q[head] <= '0;
                dom_q[head] <= '0;
                head        <= ~head;
            end
            if (do_enq) begin
                msg_q[tail] <= enq_msg;
                dom_q[tail] <= enq_domain;
                tail        <= ~tail;
            end
            count <= cnt_next(count, do_enq, do_deq);
        end
    end

endmodule

// File: rtl/vc_demux2_dd_q.sv
// vc_demux2_dd_q: domain-tagged 1-to-2 demultiplexer with a 2-entry
// scrubbing queue per output port.
//   clk, reset               : clock, async active-high reset
//   in_msg/in_domain         : message and its domain tag
//   in_sel                   : 0 -> out0, 1 -> out1
//   in_val/in_rdy            : input handshake; in_rdy reflects only the
//                              selected queue's occupancy
//   outX_msg/outX_domain     : head of queue X (0 when empty)
//   outX_val/outX_rdy        : output handshake for queue X
module vc_demux2_dd_q
    import vc_demux2_dd_q_pkg::*;
#(
    parameter int p_nbits = 1,
    parameter int p_depth = Q_DEPTH
)(
    input  logic               clk,
    input  logic               reset,
    input  logic [p_nbits-1:0] in_msg,
    input  logic [DOM_W-1:0]   in_domain,
    input  logic               in_sel,
    input  logic               in_val,
    output logic               in_rdy,
    output logic [p_nbits-1:0] out0_msg,
    output logic [DOM_W-1:0]   out0_domain,
    output logic               out0_val,
    input  logic               out0_rdy,
    output logic [p_nbits-1:0] out1_msg,
    output logic [DOM_W-1:0]   out1_domain,
    output logic               out1_val,
    input  logic               out1_rdy
);

    logic [NUM_PORTS-1:0]              q_enq_val;
    logic [NUM_PORTS-1:0]              q_enq_rdy;
    logic [NUM_PORTS-1:0]              q_deq_val;
    logic [NUM_PORTS-1:0]              q_deq_rdy;
    logic [NUM_PORTS-1:0][p_nbits-1:0] q_deq_msg;
    logic [NUM_PORTS-1:0][DOM_W-1:0]   q_deq_dom;

    assign q_deq_rdy = {out1_rdy, out0_rdy};

    generate
        for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
            // Only the selected queue sees the valid; the other is untouched.
            assign q_enq_val[i] = in_val && (in_sel == 1'(i));

            vc_queue2_dd #(
                .p_nbits (p_nbits),
                .p_depth (p_depth)
            ) u_q (
                .clk        (clk),
                .reset      (reset),
                .enq_msg    (in_msg),
                .enq_domain (in_domain),
                .enq_val    (q_enq_val[i]),
                .enq_rdy    (q_enq_rdy[i]),
                .deq_msg    (q_deq_msg[i]),
                .deq_domain (q_deq_dom[i]),
                .deq_val    (q_deq_val[i]),
                .deq_rdy    (q_deq_rdy[i])
            );
        end
    endgenerate

    // Never depends on out*_rdy: a full queue stays closed for the cycle.
    assign in_rdy = q_enq_rdy[in_sel];

    assign out0_msg    = q_deq_msg[0];
    assign out0_domain = q_deq_dom[0];
    assign out0_val    = q_deq_val[0];
    assign out1_msg    = q_deq_msg[1];
    assign out1_domain = q_deq_dom[1];
    assign out1_val    = q_deq_val[1];

endmodule

// File: tb/tb_vc_demux2_dd_q.sv
module tb_vc_demux2_dd_q;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] msg;
        logic [1:0]   dom;
    } ent_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in_msg;
    logic [1:0]   in_domain;
    logic         in_sel;
    logic         in_val;
    logic         in_rdy;
    logic [W-1:0] out0_msg, out1_msg;
    logic [1:0]   out0_domain, out1_domain;
    logic         out0_val, out1_val;
    logic         out0_rdy, out1_rdy;

    int errors = 0;
    int checks = 0;

    ent_t exp0[$];
    ent_t exp1[$];

    vc_demux2_dd_q #(.p_nbits(W), .p_depth(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_msg      (in_msg),
        .in_domain   (in_domain),
        .in_sel      (in_sel),
        .in_val      (in_val),
        .in_rdy      (in_rdy),
        .out0_msg    (out0_msg),
        .out0_domain (out0_domain),
        .out0_val    (out0_val),
        .out0_rdy    (out0_rdy),
        .out1_msg    (out1_msg),
        .out1_domain (out1_domain),
        .out1_val    (out1_val),
        .out1_rdy    (out1_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every cycle compare each port against the
    // front of its expected queue; pop when the handshake will fire.
    task automatic mon_port(input int p, input logic v, input logic [W-1:0] m,
                            input logic [1:0] d, input logic r);
        int   sz;
        ent_t e;
        sz = (p == 0) ? exp0.size() : exp1.size();
        chk($sformatf("out%0d_val", p), 32'(v), 32'(sz != 0));
        if (v && sz != 0) begin
            e = (p == 0) ? exp0[0] : exp1[0];
            chk($sformatf("out%0d_msg", p), 32'(m), 32'(e.msg));
            chk($sformatf("out%0d_domain", p), 32'(d), 32'(e.dom));
            if (r) begin
                if (p == 0) void'(exp0.pop_front());
                else        void'(exp1.pop_front());
            end
        end else if (!v) begin
            chk($sformatf("out%0d_msg_empty", p), 32'(m), 32'd0);
            chk($sformatf("out%0d_dom_empty", p), 32'(d), 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            mon_port(0, out0_val, out0_msg, out0_domain, out0_rdy);
            mon_port(1, out1_val, out1_msg, out1_domain, out1_rdy);
        end
    end

    // Hold the request until accepted (bounded); push the expectation on the
    // accepting edge. Returns at posedge+1 with in_val low.
    task automatic send(input logic sel, input logic [W-1:0] m, input logic [1:0] d,
                        input int max_cyc, output bit acc);
        in_sel = sel; in_msg = m; in_domain = d; in_val = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < max_cyc && !acc; n++) begin
            @(negedge clk);
            acc = in_rdy;
            @(posedge clk);
            if (acc) begin
                if (sel) exp1.push_back('{msg: m, dom: d});
                else     exp0.push_back('{msg: m, dom: d});
            end
            #1;
        end
        in_val = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc;
        reset = 1'b1; in_msg = '0; in_domain = '0; in_sel = 1'b0; in_val = 1'b0;
        out0_rdy = 1'b0; out1_rdy = 1'b0;
        #3;
        chk("rst_out0_val", 32'(out0_val), 32'd0);
        chk("rst_out1_val", 32'(out1_val), 32'd0);
        chk("rst_out0_msg", 32'(out0_msg), 32'd0);
        chk("rst_out1_dom", 32'(out1_domain), 32'd0);
        chk("rst_in_rdy", 32'(in_rdy), 32'd1);
        tick(); tick();
        reset = 1'b0;

        // Single route to port 1, then drain and confirm scrubbing.
        send(1'b1, 8'hA5, 2'd2, 2, acc);
        chk("route_acc", 32'(acc), 32'd1);
        chk("route_out1_val", 32'(out1_val), 32'd1);
        chk("route_out1_msg", 32'(out1_msg), 32'hA5);
        chk("route_out1_dom", 32'(out1_domain), 32'd2);
        chk("route_out0_val", 32'(out0_val), 32'd0);
        out1_rdy = 1'b1;
        tick();
        out1_rdy = 1'b0;
        chk("scrub_out1_val", 32'(out1_val), 32'd0);
        chk("scrub_out1_msg", 32'(out1_msg), 32'd0);
        chk("scrub_out1_dom", 32'(out1_domain), 32'd0);
        chk("scrub_msg_q0", 32'(dut.g_port[1].u_q.msg_q[0]), 32'd0);
        chk("scrub_msg_q1", 32'(dut.g_port[1].u_q.msg_q[1]), 32'd0);
        chk("scrub_dom_q0", 32'(dut.g_port[1].u_q.dom_q[0]), 32'd0);
        chk("scrub_dom_q1", 32'(dut.g_port[1].u_q.dom_q[1]), 32'd0);

        // Fill queue 0 and hold backpressure.
        send(1'b0, 8'h11, 2'd0, 2, acc);
        chk("fill_acc1", 32'(acc), 32'd1);
        send(1'b0, 8'h22, 2'd1, 2, acc);
        chk("fill_acc2", 32'(acc), 32'd1);
        in_sel = 1'b0; in_msg = 8'h33; in_domain = 2'd3; in_val = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("full_in_rdy", 32'(in_rdy), 32'd0);
            tick();
        end
        // Full with consumer ready: pop only, no enqueue this edge.
        out0_rdy = 1'b1;
        @(negedge clk);
        chk("full_rdy_in_rdy", 32'(in_rdy), 32'd0);
        tick();
        chk("after_pop_val", 32'(out0_val), 32'd1);
        chk("after_pop_msg", 32'(out0_msg), 32'h22);
        chk("after_pop_dom", 32'(out0_domain), 32'd1);
        // Count 1: simultaneous enq (0x33) and deq (0x22).
        send(1'b0, 8'h33, 2'd3, 2, acc);
        chk("simul_acc", 32'(acc), 32'd1);
        out0_rdy = 1'b0;
        chk("simul_head_msg", 32'(out0_msg), 32'h33);
        chk("simul_head_dom", 32'(out0_domain), 32'd3);

        // Isolation: queue 0 full and stalled, port 1 still flows.
        send(1'b0, 8'h44, 2'd1, 2, acc);
        chk("iso_fill_acc", 32'(acc), 32'd1);
        in_sel = 1'b0; #1;
        chk("iso_rdy_sel0", 32'(in_rdy), 32'd0);
        in_sel = 1'b1; #1;
        chk("iso_rdy_sel1", 32'(in_rdy), 32'd1);
        send(1'b1, 8'h77, 2'd1, 2, acc);
        chk("iso_acc", 32'(acc), 32'd1);
        chk("iso_out1_msg", 32'(out1_msg), 32'h77);
        chk("iso_out1_dom", 32'(out1_domain), 32'd1);
        chk("iso_out0_msg", 32'(out0_msg), 32'h33);
        chk("iso_out0_dom", 32'(out0_domain), 32'd3);

        // Both ports dequeue while enqueueing; then drain everything.
        out0_rdy = 1'b1; out1_rdy = 1'b1;
        send(1'b0, 8'h55, 2'd0, 4, acc);
        chk("both_acc", 32'(acc), 32'd1);
        for (int n = 0; n < 20 && (exp0.size() + exp1.size()) != 0; n++) tick();
        tick();
        chk("drain_out0_val", 32'(out0_val), 32'd0);
        chk("drain_out1_val", 32'(out1_val), 32'd0);
        chk("drain_pending", 32'(exp0.size() + exp1.size()), 32'd0);

        // Reset mid-traffic with two entries in queue 0.
        out0_rdy = 1'b0; out1_rdy = 1'b0;
        send(1'b0, 8'h66, 2'd2, 2, acc);
        send(1'b0, 8'h88, 2'd3, 2, acc);
        chk("pre_rst_val", 32'(out0_val), 32'd1);
        in_sel = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_val", 32'(out0_val), 32'd0);
        chk("mid_rst_msg", 32'(out0_msg), 32'd0);
        chk("mid_rst_dom", 32'(out0_domain), 32'd0);
        chk("mid_rst_in_rdy", 32'(in_rdy), 32'd1);
        exp0.delete(); exp1.delete();
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_val", 32'(out0_val), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
